// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous RAM.
// Each access is IDLE -> ISSUE -> WAIT, with fixed data priority or round-robin.
module mem_arbiter #(
  parameter int unsigned PRIO_DATA = 1,
  localparam int unsigned AW = 8,
  localparam int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   pick_data;
  logic   last_data;
  logic   sel_data;
  logic   lat_we;

  // Next-state and winner selection; round-robin favours the port not granted last.
  always_comb begin
    state_next = state;
    pick_data  = 1'b0;
    if (PRIO_DATA != 0) begin
      pick_data = d_req;
    end else begin
      pick_data = d_req && (!if_req || !last_data);
    end
    case (state)
      IDLE:    if (if_req || d_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs: request latch in IDLE, RAM strobe during ISSUE, read return after WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt    <= 1'b0;
      if_rdata  <= '0;
      if_rvalid <= 1'b0;
      d_gnt     <= 1'b0;
      d_rdata   <= '0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      last_data <= 1'b1;
      sel_data  <= 1'b0;
      lat_we    <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (state_next == ISSUE) begin
            sel_data  <= pick_data;
            last_data <= pick_data;
            lat_we    <= pick_data && d_we;
            if_gnt    <= !pick_data;
            d_gnt     <= pick_data;
            mem_en    <= 1'b1;
            mem_we    <= pick_data && d_we;
            mem_addr  <= pick_data ? d_addr : if_addr;
            mem_wdata <= pick_data ? d_wdata : DW'(0);
          end
        end
        WAIT: begin
          if (!lat_we) begin
            if (sel_data) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
